// File: rtl/sys_array_if.sv
// Pixel stream bundle for the 3x3 convolution engine: input pixel, enable,
// window-valid qualifier and the registered result pixel.
interface sys_array_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pixIn;
  logic              enable;
  logic              num_pix_ok;
  logic [DATA_W-1:0] pixOut;

  modport master (
    output pixIn,
    output enable,
    output num_pix_ok,
    input  pixOut
  );

  modport slave (
    input  pixIn,
    input  enable,
    input  num_pix_ok,
    output pixOut
  );
endinterface

// File: rtl/sys_array.sv
// Streaming 3x3 Gaussian convolution (1 2 1 / 2 4 2 / 1 2 1, >>4).
// Two row-deep line buffers feed a 3x3 shift window; the kernel sum of the
// window is truncated to a pixel and registered once per enabled cycle.
module sys_array #(
  parameter int IMG_WIDTH = 100,
  parameter int DATA_W    = 8
) (
  input logic        clk,
  input logic        rst,
  sys_array_if.slave bus
);

  // Kernel weights total 16, so four extra bits hold the full sum.
  localparam int SUM_W = DATA_W + 4;

  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] win_p0 [3][3];
  logic              vld_p0;
  logic [SUM_W-1:0]  sum_p0;
  logic [DATA_W-1:0] pix_out_p1;

  // Divide by the kernel weight total; plain truncation, the result
  // can never exceed the pixel range so no clipping is needed.
  function automatic logic [DATA_W-1:0] trunc_div16(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:4];
  endfunction

  // ---- stage p0: line buffers and 3x3 window ----

  // Line buffers shift one pixel per accept; the LB1 tail feeds LB2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
    end else if (bus.enable) begin
      lb1[0] <= bus.pixIn;
      lb2[0] <= lb1[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb1[i] <= lb1[i-1];
        lb2[i] <= lb2[i-1];
      end
    end
  end

  // Window shifts left; column 2 loads the newest pixel of each row,
  // and the qualifier is captured alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_p0[r][c] <= '0;
        end
      end
      vld_p0 <= 1'b0;
    end else if (bus.enable) begin
      for (int r = 0; r < 3; r++) begin
        win_p0[r][0] <= win_p0[r][1];
        win_p0[r][1] <= win_p0[r][2];
      end
      win_p0[2][2] <= bus.pixIn;
      win_p0[1][2] <= lb1[IMG_WIDTH-1];
      win_p0[0][2] <= lb2[IMG_WIDTH-1];
      vld_p0       <= bus.num_pix_ok;
    end
  end

  // Weighted window sum: corners x1, edges x2, centre x4, as shifts.
  always_comb begin
    sum_p0 = SUM_W'(win_p0[0][0])
           + (SUM_W'(win_p0[0][1]) << 1)
           + SUM_W'(win_p0[0][2])
           + (SUM_W'(win_p0[1][0]) << 1)
           + (SUM_W'(win_p0[1][1]) << 2)
           + (SUM_W'(win_p0[1][2]) << 1)
           + SUM_W'(win_p0[2][0])
           + (SUM_W'(win_p0[2][1]) << 1)
           + SUM_W'(win_p0[2][2]);
  end

  // ---- stage p1: registered, qualified result ----

  // Output register; unqualified windows are forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_out_p1 <= '0;
    end else if (bus.enable) begin
      pix_out_p1 <= vld_p0 ? trunc_div16(sum_p0) : '0;
    end
  end

  assign bus.pixOut = pix_out_p1;

endmodule

// File: tb/tb_sys_array.sv
// Bench for sys_array: a history-based golden model pushes the expected
// output for each accepted pixel; it is popped one enabled edge later.
module tb_sys_array;

  localparam int W = 100;

  logic clk;
  logic rst;

  sys_array_if #(.DATA_W(8)) bus ();

  sys_array #(.IMG_WIDTH(W), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hist[$];
  int sb[$];

  function automatic int hpix(int idx);
    if (idx < 0) return 0;
    return hist[idx];
  endfunction

  // Expected result for the window completed by accepted pixel k.
  function automatic int model_res(int k);
    int s;
    int coef;
    s = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        coef = ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
        s += coef * hpix(k - (2 - r) * W - (2 - c));
      end
    end
    return s >> 4;
  endfunction

  task automatic model_clear();
    hist.delete();
    sb.delete();
    sb.push_back(0);
  endtask

  task automatic accept(input int p, input bit ok);
    bus.pixIn      = p[7:0];
    bus.num_pix_ok = ok;
    bus.enable     = 1'b1;
    @(posedge clk);
    #1;
    hist.push_back(p);
    sb.push_back(ok ? model_res(hist.size() - 1) : 0);
  endtask

  task automatic idle();
    bus.enable = 1'b0;
    bus.pixIn  = 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    bus.enable     = 1'b1;
    bus.num_pix_ok = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pixOut !== 8'd0) begin
      errors++;
      $display("FAIL reset_async got=%0d exp=0", bus.pixOut);
    end
    for (int i = 0; i < 2; i++) begin
      bus.pixIn = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      checks++;
      if (bus.pixOut !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%0d exp=0", i, bus.pixOut);
      end
    end
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_constant();
    int e;
    int nz_early;
    do_reset();
    nz_early = 0;
    for (int i = 0; i < 300; i++) begin
      accept(100, i >= 202);
      e = sb.pop_front();
      checks++;
      if (bus.pixOut !== 8'(e)) begin
        errors++;
        $display("FAIL const i=%0d got=%0d exp=%0d", i, bus.pixOut, e);
      end
      if (i <= 202 && bus.pixOut !== 8'd0) nz_early++;
    end
    checks++;
    if (nz_early != 0) begin
      errors++;
      $display("FAIL const_early nonzero=%0d exp=0", nz_early);
    end
    checks++;
    if (bus.pixOut !== 8'd100) begin
      errors++;
      $display("FAIL const_final got=%0d exp=100", bus.pixOut);
    end
  endtask

  task automatic test_impulse();
    int e;
    int nz_val[$];
    int nz_idx[$];
    int tab[9];
    tab = '{10, 20, 10, 20, 40, 20, 10, 20, 10};
    do_reset();
    for (int i = 0; i < 500; i++) begin
      accept((i == 250) ? 160 : 0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus.pixOut !== 8'(e)) begin
        errors++;
        $display("FAIL impulse i=%0d got=%0d exp=%0d", i, bus.pixOut, e);
      end
      if (bus.pixOut !== 8'd0) begin
        nz_val.push_back(int'(bus.pixOut));
        nz_idx.push_back(i);
      end
    end
    checks++;
    if (nz_val.size() != 9) begin
      errors++;
      $display("FAIL impulse_count got=%0d exp=9", nz_val.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (nz_val[j] != tab[j]) begin
          errors++;
          $display("FAIL impulse_val j=%0d got=%0d exp=%0d", j, nz_val[j], tab[j]);
        end
      end
      checks++;
      if (nz_idx[3] - nz_idx[0] != W || nz_idx[6] - nz_idx[3] != W || nz_idx[0] != 251) begin
        errors++;
        $display("FAIL impulse_spacing got=%0d,%0d,%0d exp=251,%0d,%0d",
                 nz_idx[0], nz_idx[3], nz_idx[6], 251 + W, 251 + 2 * W);
      end
    end
  endtask

  task automatic test_full_scale();
    int e;
    int nz;
    int vals[2];
    vals = '{255, 1};
    for (int v = 0; v < 2; v++) begin
      do_reset();
      for (int i = 0; i < 260; i++) begin
        accept(vals[v], i >= 202);
        e = sb.pop_front();
        checks++;
        if (bus.pixOut !== 8'(e)) begin
          errors++;
          $display("FAIL flat v=%0d i=%0d got=%0d exp=%0d", vals[v], i, bus.pixOut, e);
        end
      end
      checks++;
      if (bus.pixOut !== 8'(vals[v])) begin
        errors++;
        $display("FAIL flat_final got=%0d exp=%0d", bus.pixOut, vals[v]);
      end
    end
    do_reset();
    nz = 0;
    for (int i = 0; i < 500; i++) begin
      accept((i == 250) ? 1 : 0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus.pixOut !== 8'(e)) begin
        errors++;
        $display("FAIL trunc i=%0d got=%0d exp=%0d", i, bus.pixOut, e);
      end
      if (bus.pixOut !== 8'd0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL trunc_count got=%0d exp=0", nz);
    end
  endtask

  task automatic test_stall();
    int e;
    logic [7:0] held;
    do_reset();
    for (int i = 0; i < 320; i++) begin
      if (i == 260) begin
        held = bus.pixOut;
        for (int s = 0; s < 5; s++) begin
          idle();
          checks++;
          if (bus.pixOut !== held) begin
            errors++;
            $display("FAIL stall_hold s=%0d got=%0d exp=%0d", s, bus.pixOut, held);
          end
        end
      end
      accept(int'($urandom_range(0, 255)), 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus.pixOut !== 8'(e)) begin
        errors++;
        $display("FAIL stall i=%0d got=%0d exp=%0d", i, bus.pixOut, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      accept(int'($urandom_range(1, 255)), i >= 202);
      e = sb.pop_front();
      checks++;
      if (bus.pixOut !== 8'(e)) begin
        errors++;
        $display("FAIL pre_rst i=%0d got=%0d exp=%0d", i, bus.pixOut, e);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pixOut !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_async got=%0d exp=0", bus.pixOut);
    end
    bus.enable = 1'b1;
    bus.pixIn  = 8'd200;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pixOut !== 8'd0) begin
      errors++;
      $display("FAIL rst_dominates got=%0d exp=0", bus.pixOut);
    end
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 300; i++) begin
      accept(int'($urandom_range(0, 255)), 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus.pixOut !== 8'(e)) begin
        errors++;
        $display("FAIL post_rst i=%0d got=%0d exp=%0d", i, bus.pixOut, e);
      end
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.enable     = 1'b0;
    bus.num_pix_ok = 1'b0;
    bus.pixIn      = 8'd0;
    test_reset();
    test_constant();
    test_impulse();
    test_full_scale();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
